// File: rtl/multi_clk_divider.sv
// multi_clk_divider: NCH runtime-programmable clock/tick dividers
// sharing one system clock, with per-channel pause and global resync.
module multi_clk_divider #(
    parameter int          NCH         = 4,
    parameter int          CW          = 23,
    parameter int unsigned DEFAULT_DIV = 2500000,
    parameter int          CHW         = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_mode,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);

    localparam logic [CW-1:0] DIV_RST = CW'(DEFAULT_DIV);

    logic [CW-1:0]  div [NCH];
    logic [CW-1:0]  cnt [NCH];
    logic [NCH-1:0] mode;
    logic [NCH-1:0] wsel;
    logic [NCH-1:0] stopped;
    logic [NCH-1:0] wrap;

    // Out-of-range channel numbers decode to no channel at all.
    always_comb begin
        wsel    = '0;
        stopped = '0;
        wrap    = '0;
        for (int k = 0; k < NCH; k++) begin
            wsel[k]    = cfg_we && (int'(cfg_ch) == k);
            stopped[k] = (div[k] == '0);
            wrap[k]    = !stopped[k] && (cnt[k] == div[k] - CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                div[k]     <= DIV_RST;
                mode[k]    <= 1'b0;
                cnt[k]     <= '0;
                clk_out[k] <= 1'b0;
                tick[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wsel[k]) begin
                    div[k]     <= cfg_div;
                    mode[k]    <= cfg_mode;
                    cnt[k]     <= '0;
                    clk_out[k] <= 1'b0;
                    tick[k]    <= 1'b0;
                end else if (sync || (en[k] && stopped[k])) begin
                    cnt[k]     <= '0;
                    clk_out[k] <= 1'b0;
                    tick[k]    <= 1'b0;
                end else if (!en[k]) begin
                    tick[k] <= 1'b0;
                end else if (wrap[k]) begin
                    cnt[k]     <= '0;
                    tick[k]    <= 1'b1;
                    clk_out[k] <= mode[k] ? 1'b1 : !clk_out[k];
                end else begin
                    cnt[k]  <= cnt[k] + CW'(1);
                    tick[k] <= 1'b0;
                    if (mode[k])
                        clk_out[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider: NCH=5, CW=4, DEFAULT_DIV=4
// so that an out-of-range channel and the largest divide are reachable.
module tb_multi_clk_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] en;
    logic       sync;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [3:0] cfg_div;
    logic       cfg_mode;
    logic [4:0] clk_out;
    logic [4:0] tick;

    int errs = 0;
    int checks = 0;
    logic [4:0] ec;
    logic [4:0] et;

    multi_clk_divider #(
        .NCH(5),
        .CW(4),
        .DEFAULT_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sync(sync),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_mode(cfg_mode),
        .clk_out(clk_out),
        .tick(tick)
    );

    always #5 clk = !clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 5'h1f;
        sync = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = 3'd0;
        cfg_div = 4'd0;
        cfg_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (clk_out !== 5'h00 || tick !== 5'h00) begin
                errs++;
                $display("FAIL reset_outputs: clk_out=%b tick=%b want 00000/00000", clk_out, tick);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_default();
        for (int i = 1; i <= 16; i++) begin
            cyc();
            ec = (((i / 4) % 2) == 1) ? 5'h1f : 5'h00;
            et = ((i % 4) == 0) ? 5'h1f : 5'h00;
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errs++;
                $display("FAIL default_run edge %0d: clk_out=%b tick=%b want %b/%b", i, clk_out, tick, ec, et);
            end
        end
    endtask

    task automatic test_write_pulse();
        int n;
        cfg_we = 1'b1;
        cfg_ch = 3'd1;
        cfg_div = 4'd3;
        cfg_mode = 1'b1;
        cyc();
        cfg_we = 1'b0;
        checks++;
        if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0 || dut.cnt[1] !== 4'd0) begin
            errs++;
            $display("FAIL write_restart: clk_out1=%b tick1=%b cnt1=%0d want 0/0/0", clk_out[1], tick[1], dut.cnt[1]);
        end
        for (int j = 1; j <= 9; j++) begin
            cyc();
            n = 17 + j;
            ec = (((n / 4) % 2) == 1) ? 5'h1d : 5'h00;
            et = ((n % 4) == 0) ? 5'h1d : 5'h00;
            ec[1] = ((j % 3) == 0);
            et[1] = ((j % 3) == 0);
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errs++;
                $display("FAIL write_pulse j=%0d: clk_out=%b tick=%b want %b/%b", j, clk_out, tick, ec, et);
            end
        end
    endtask

    task automatic test_pause();
        logic [15:0] clk2_exp;
        logic [15:0] tick2_exp;
        clk2_exp = 16'h1ff0;
        tick2_exp = 16'h2010;
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        for (int m = 1; m <= 14; m++) begin
            cyc();
            ec = (((m / 4) % 2) == 1) ? 5'h1f : 5'h00;
            et = ((m % 4) == 0) ? 5'h1f : 5'h00;
            ec[1] = ((m % 3) == 0);
            et[1] = ((m % 3) == 0);
            ec[2] = clk2_exp[m];
            et[2] = tick2_exp[m];
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errs++;
                $display("FAIL pause m=%0d: clk_out=%b tick=%b want %b/%b", m, clk_out, tick, ec, et);
            end
            if (m == 6) en[2] = 1'b0;
            if (m == 11) en[2] = 1'b1;
        end
    endtask

    task automatic test_sync();
        cfg_we = 1'b1;
        cfg_ch = 3'd3;
        cfg_div = 4'd4;
        cfg_mode = 1'b0;
        cyc();
        cfg_we = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        checks++;
        if (clk_out[0] !== 1'b1 || clk_out[3] !== 1'b1) begin
            errs++;
            $display("FAIL sync_pre: clk_out0=%b clk_out3=%b want 1/1", clk_out[0], clk_out[3]);
        end
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        checks++;
        if (clk_out !== 5'h00 || tick !== 5'h00) begin
            errs++;
            $display("FAIL sync_clear: clk_out=%b tick=%b want 00000/00000", clk_out, tick);
        end
        for (int j = 1; j <= 9; j++) begin
            cyc();
            ec = (((j / 4) % 2) == 1) ? 5'h1f : 5'h00;
            et = ((j % 4) == 0) ? 5'h1f : 5'h00;
            ec[1] = ((j % 3) == 0);
            et[1] = ((j % 3) == 0);
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errs++;
                $display("FAIL sync_align j=%0d: clk_out=%b tick=%b want %b/%b", j, clk_out, tick, ec, et);
            end
        end
    endtask

    task automatic test_corner();
        cfg_we = 1'b1;
        cfg_ch = 3'd0; cfg_div = 4'd0; cfg_mode = 1'b0;
        cyc();
        cfg_ch = 3'd1; cfg_div = 4'd1; cfg_mode = 1'b0;
        cyc();
        cfg_ch = 3'd2; cfg_div = 4'd1; cfg_mode = 1'b1;
        cyc();
        cfg_ch = 3'd3; cfg_div = 4'd15; cfg_mode = 1'b0;
        cyc();
        cfg_we = 1'b0;
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        for (int j = 1; j <= 61; j++) begin
            cyc();
            ec[0] = 1'b0;
            ec[1] = ((j % 2) == 1);
            ec[2] = 1'b1;
            ec[3] = (((j / 15) % 2) == 1);
            ec[4] = (((j / 4) % 2) == 1);
            et[0] = 1'b0;
            et[1] = 1'b1;
            et[2] = 1'b1;
            et[3] = ((j % 15) == 0);
            et[4] = ((j % 4) == 0);
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errs++;
                $display("FAIL corner j=%0d: clk_out=%b tick=%b want %b/%b", j, clk_out, tick, ec, et);
            end
        end
    endtask

    task automatic test_abnormal();
        cfg_we = 1'b1;
        cfg_ch = 3'd0;
        cfg_div = 4'd2;
        cfg_mode = 1'b0;
        sync = 1'b1;
        cyc();
        cfg_we = 1'b0;
        sync = 1'b0;
        checks++;
        if (clk_out !== 5'h00 || tick !== 5'h00) begin
            errs++;
            $display("FAIL write_plus_sync: clk_out=%b tick=%b want 00000/00000", clk_out, tick);
        end
        for (int j = 1; j <= 12; j++) begin
            cyc();
            ec[0] = (((j / 2) % 2) == 1);
            ec[1] = ((j % 2) == 1);
            ec[2] = 1'b1;
            ec[3] = 1'b0;
            ec[4] = (((j / 4) % 2) == 1);
            et[0] = ((j % 2) == 0);
            et[1] = 1'b1;
            et[2] = 1'b1;
            et[3] = 1'b0;
            et[4] = ((j % 4) == 0);
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errs++;
                $display("FAIL abnormal j=%0d: clk_out=%b tick=%b want %b/%b", j, clk_out, tick, ec, et);
            end
            if (j == 6) begin
                cfg_we = 1'b1;
                cfg_ch = 3'd5;
                cfg_div = 4'd0;
                cfg_mode = 1'b1;
            end
            if (j == 7) cfg_we = 1'b0;
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        checks++;
        if (clk_out !== 5'h00 || tick !== 5'h00) begin
            errs++;
            $display("FAIL mid_reset: clk_out=%b tick=%b want 00000/00000", clk_out, tick);
        end
        for (int j = 1; j <= 8; j++) begin
            cyc();
            ec = (((j / 4) % 2) == 1) ? 5'h1f : 5'h00;
            et = ((j % 4) == 0) ? 5'h1f : 5'h00;
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errs++;
                $display("FAIL post_reset j=%0d: clk_out=%b tick=%b want %b/%b", j, clk_out, tick, ec, et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_write_pulse();
        test_pause();
        test_sync();
        test_corner();
        test_abnormal();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
- Parametrised multi-channel successor to the single fixed 50 ms divider.
- Generates NCH independent divided clocks/ticks from one system clock (timebases for the car simulation: blinkers, speed sampling, display scan).
- Each channel has a runtime-programmable divide value, a square/pulse mode and a pause enable.
- A global sync input realigns all channels.

Parameters:
- NCH, 4, number of output channels (>=2).
- CW, 23, counter and divide-value width.
- DEFAULT_DIV, 2500000, per-channel divide value loaded at reset. 2500000 gives 50 ms square period at 100 MHz.
- CHW, $clog2(NCH), channel-select width (derived, do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  NCH  per-channel run enable; low = pause.
- sync  in  1  one-cycle strobe; restarts every channel.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CHW  channel addressed by the write.
- cfg_div  in  CW  new divide value D.
- cfg_mode  in  1  0 = square, 1 = pulse.
- clk_out  out  NCH  divided output per channel (registered).
- tick  out  NCH  one-cycle wrap strobe per channel (registered).

Behaviour:
- Per-channel state: div[CW], mode, cnt[CW], clk_out bit, tick bit.
- Reset (rst==0 at a clk edge):
  - div=DEFAULT_DIV, mode=0, cnt=0, clk_out=0, tick=0, for all channels.
  - Reset takes effect at that edge only; no asynchronous path.
- Priority per channel, per edge: reset > cfg write to this channel > sync > paused > run.
- Cfg write (cfg_we=1, cfg_ch==k, k<NCH):
  - div[k]<=cfg_div, mode[k]<=cfg_mode, cnt[k]<=0, clk_out[k]<=0, tick[k]<=0.
  - Other channels are unaffected.
  - cfg_ch>=NCH: write ignored.
- Sync: all channels not being written get cnt<=0, clk_out<=0, tick<=0.
- Paused (en[k]=0): cnt and clk_out hold; tick<=0.
- Run (en[k]=1, D=div[k]):
  - D==0: channel stopped; cnt<=0, clk_out<=0, tick<=0.
  - cnt==D-1: cnt<=0 and tick<=1. Square mode: clk_out toggles. Pulse mode: clk_out<=1.
  - Otherwise: cnt<=cnt+1 and tick<=0. Pulse mode: clk_out<=0. Square mode: clk_out holds.
- Resulting timing:
  - Square mode: period 2*D clk cycles, 50% duty.
  - Pulse mode: clk_out equals tick; one-cycle high every D cycles.
  - First wrap is on the D-th enabled edge after restart (reset release, write or sync).
  - D==1 square: toggles every cycle. D==1 pulse: clk_out and tick stay high continuously.
- Arithmetic: compare cnt==D-1 at CW bits; cnt never exceeds D-1.
- Mid-count changes:
  - Lowering D by a write always restarts, so no wrap-around overrun is possible.
  - Changing en never resets cnt.
- Mode change takes effect only via a cfg write, which also restarts the channel.

Test Plan:
1. Reset and default run (sim DEFAULT_DIV=4, en=all 1): hold rst=0 for 2 cycles, then release.
   - All outputs are 0 during reset.
   - clk_out[0] first rises on the 4th edge after release, period 8; tick[0] high 1 cycle every 4.
2. Write ch1 D=3, mode=1:
   - Next cycle cnt[1]=0 and clk_out[1]=0.
   - clk_out[1]==tick[1], high on edges 3, 6, 9 after the write.
   - ch0 timing is undisturbed.
3. Pause: deassert en[2] when cnt[2]=2 (D=4) for 5 cycles.
   - clk_out[2] and cnt[2] are frozen; tick[2]=0.
   - The wrap occurs exactly 5 cycles later than unpaused.
4. Sync: ch0 and ch3 both D=4 but out of phase; pulse sync.
   - Both outputs are 0 the next cycle.
   - Both then toggle on the same edges thereafter.
5. Corner divide values:
   - D=0: clk_out and tick stay 0 indefinitely.
   - D=1 square: clk_out toggles every cycle.
   - D=1 pulse: clk_out=tick=1 continuously.
   - D=2^CW-1 (reduce CW to 4 in sim, D=15): square period 30.
6. Simultaneous and abnormal events:
   - cfg_we to ch0 plus sync in the same cycle: ch0 takes the new D; others resync.
   - cfg_ch=NCH: no change.
   - rst=0 mid-count: all channels are cleared to reset values at that edge.
